// File: rtl/perceptron_train_seq_if.sv
// Sample-memory read bus plus sample handshake between the training sequencer and its
// memories/datapath; master = sequencer, slave = memories + MAC/update datapath.
interface perceptron_train_seq_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              mem_ena;
  logic              mem_wr_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] x1_data;
  logic [DATA_W-1:0] x2_data;
  logic [DATA_W-1:0] t_data;
  logic              samp_valid;
  logic [DATA_W-1:0] samp_x1;
  logic [DATA_W-1:0] samp_x2;
  logic [DATA_W-1:0] samp_t;
  logic              samp_ready;
  logic              samp_err;

  modport master (
    output mem_ena, mem_wr_rd, mem_addr,
    input  x1_data, x2_data, t_data,
    output samp_valid, samp_x1, samp_x2, samp_t,
    input  samp_ready, samp_err
  );

  modport slave (
    input  mem_ena, mem_wr_rd, mem_addr,
    output x1_data, x2_data, t_data,
    input  samp_valid, samp_x1, samp_x2, samp_t,
    output samp_ready, samp_err
  );
endinterface

// File: rtl/perceptron_train_seq.sv
// Perceptron training-loop sequencer: 3 cycles/sample, or 1 sample/cycle after a 2-cycle fill
// with PERCEPTRON_PREFETCH_EN; samples held on samp_valid until samp_ready, fetches stall meanwhile.
module perceptron_train_seq #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  parameter int EPOCH_W   = 8,
  parameter int MAX_EPOCH = 100
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_W:0]        n_samples,
  perceptron_train_seq_if.master bus,
  output logic                   busy,
  output logic                   done,
  output logic                   converged,
  output logic [EPOCH_W-1:0]     epoch_cnt,
  output logic [ADDR_W:0]        err_cnt
);
  typedef enum logic [2:0] {IDLE, FETCH, CAPT, ISSUE, EPOCH_END, DONE} state_t;

  localparam logic [ADDR_W:0]    ONE_A = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [EPOCH_W-1:0] ONE_E = {{(EPOCH_W-1){1'b0}}, 1'b1};
  localparam logic [EPOCH_W-1:0] MAX_E = EPOCH_W'(MAX_EPOCH);

  state_t             state;
  logic [ADDR_W:0]    n_lat;
  logic [ADDR_W:0]    idx;
  logic [ADDR_W:0]    idx_p1;
  logic [ADDR_W:0]    err_inc;
  logic [EPOCH_W-1:0] epoch_nxt;
  logic               hs;
  logic               last;

  assign hs            = bus.samp_valid & bus.samp_ready;
  assign last          = (idx == n_lat - ONE_A);
  assign idx_p1        = idx + ONE_A;
  assign err_inc       = {{ADDR_W{1'b0}}, bus.samp_err};
  assign epoch_nxt     = epoch_cnt + ONE_E;
  assign bus.mem_wr_rd = 1'b0;

`ifdef PERCEPTRON_PREFETCH_EN
  logic              run;
  logic              rd_pend;
  logic              buf_vld;
  logic              issue;
  logic              out_free;
  logic [1:0]        occ;
  logic [ADDR_W:0]   fetch_idx;
  logic [DATA_W-1:0] buf_x1;
  logic [DATA_W-1:0] buf_x2;
  logic [DATA_W-1:0] buf_t;

  // Output reg + one buffer entry + one read in flight never exceed two samples in total.
  assign run          = (state == FETCH) || (state == CAPT) || (state == ISSUE);
  assign occ          = {1'b0, bus.samp_valid} + {1'b0, buf_vld} + {1'b0, rd_pend};
  assign issue        = run && (fetch_idx != n_lat) && ((occ < 2'd2) || ((occ == 2'd2) && hs));
  assign out_free     = !bus.samp_valid || hs;
  assign bus.mem_ena  = issue;
  assign bus.mem_addr = fetch_idx[ADDR_W-1:0];
`else
  logic              mem_ena_r;
  logic [ADDR_W-1:0] mem_addr_r;

  assign bus.mem_ena  = mem_ena_r;
  assign bus.mem_addr = mem_addr_r;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      n_lat          <= '0;
      idx            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      converged      <= 1'b0;
      epoch_cnt      <= '0;
      err_cnt        <= '0;
      bus.samp_valid <= 1'b0;
      bus.samp_x1    <= '0;
      bus.samp_x2    <= '0;
      bus.samp_t     <= '0;
`ifdef PERCEPTRON_PREFETCH_EN
      rd_pend        <= 1'b0;
      buf_vld        <= 1'b0;
      fetch_idx      <= '0;
      buf_x1         <= '0;
      buf_x2         <= '0;
      buf_t          <= '0;
`else
      mem_ena_r      <= 1'b0;
      mem_addr_r     <= '0;
`endif
    end else begin
`ifdef PERCEPTRON_PREFETCH_EN
      if (run) begin
        rd_pend <= issue;
        if (issue) fetch_idx <= fetch_idx + ONE_A;
        if (hs && buf_vld) begin
          bus.samp_x1    <= buf_x1;
          bus.samp_x2    <= buf_x2;
          bus.samp_t     <= buf_t;
          bus.samp_valid <= 1'b1;
          if (rd_pend) begin
            buf_x1 <= bus.x1_data;
            buf_x2 <= bus.x2_data;
            buf_t  <= bus.t_data;
          end else begin
            buf_vld <= 1'b0;
          end
        end else if (rd_pend && out_free) begin
          bus.samp_x1    <= bus.x1_data;
          bus.samp_x2    <= bus.x2_data;
          bus.samp_t     <= bus.t_data;
          bus.samp_valid <= 1'b1;
        end else if (rd_pend) begin
          buf_x1  <= bus.x1_data;
          buf_x2  <= bus.x2_data;
          buf_t   <= bus.t_data;
          buf_vld <= 1'b1;
        end else if (hs) begin
          bus.samp_valid <= 1'b0;
        end
      end
`endif
      case (state)
        IDLE, DONE: begin
          if (start) begin
            epoch_cnt <= '0;
            err_cnt   <= '0;
            converged <= 1'b0;
            idx       <= '0;
            if (n_samples == '0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              n_lat <= n_samples;
              done  <= 1'b0;
              busy  <= 1'b1;
              state <= FETCH;
`ifdef PERCEPTRON_PREFETCH_EN
              fetch_idx <= '0;
              rd_pend   <= 1'b0;
              buf_vld   <= 1'b0;
`else
              mem_ena_r  <= 1'b1;
              mem_addr_r <= '0;
`endif
            end
          end
        end
        FETCH: begin
`ifndef PERCEPTRON_PREFETCH_EN
          mem_ena_r <= 1'b0;
`endif
          state <= CAPT;
        end
        CAPT: begin
`ifndef PERCEPTRON_PREFETCH_EN
          bus.samp_x1    <= bus.x1_data;
          bus.samp_x2    <= bus.x2_data;
          bus.samp_t     <= bus.t_data;
          bus.samp_valid <= 1'b1;
`endif
          state <= ISSUE;
        end
        ISSUE: begin
          if (hs) begin
            err_cnt <= err_cnt + err_inc;
            if (last) begin
              state <= EPOCH_END;
            end else begin
              idx <= idx_p1;
            end
`ifndef PERCEPTRON_PREFETCH_EN
            bus.samp_valid <= 1'b0;
            if (!last) begin
              mem_ena_r  <= 1'b1;
              mem_addr_r <= idx_p1[ADDR_W-1:0];
              state      <= FETCH;
            end
`endif
          end
        end
        EPOCH_END: begin
          epoch_cnt <= epoch_nxt;
          if (err_cnt == '0) begin
            converged <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else if (epoch_nxt == MAX_E) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            err_cnt <= '0;
            idx     <= '0;
            state   <= FETCH;
`ifdef PERCEPTRON_PREFETCH_EN
            fetch_idx <= '0;
            rd_pend   <= 1'b0;
            buf_vld   <= 1'b0;
`else
            mem_ena_r  <= 1'b1;
            mem_addr_r <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_perceptron_train_seq.sv
// Bench for perceptron_train_seq: table of training runs plus reset-abort and stall sequences,
// with every handed-off sample compared against a scoreboard queue.
module tb_perceptron_train_seq;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 16;
  localparam int EPOCH_W   = 8;
  localparam int MAX_EPOCH = 3;
  localparam int NW        = ADDR_W + 1;
  localparam int NV        = 8;
`ifdef PERCEPTRON_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  typedef struct {
    int n;
    int mode;
    int bp;
    bit poke;
    int ep;
    bit conv;
    int err;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [ADDR_W:0]    n_samples = '0;
  logic               busy;
  logic               done;
  logic               converged;
  logic [EPOCH_W-1:0] epoch_cnt;
  logic [ADDR_W:0]    err_cnt;

  perceptron_train_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  perceptron_train_seq #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .EPOCH_W(EPOCH_W), .MAX_EPOCH(MAX_EPOCH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples), .bus(bus),
    .busy(busy), .done(done), .converged(converged), .epoch_cnt(epoch_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] m_x1 [0:1023];
  logic [DATA_W-1:0] m_x2 [0:1023];
  logic [DATA_W-1:0] m_t  [0:1023];

  always @(posedge clk) begin
    if (bus.mem_ena) begin
      bus.x1_data <= m_x1[bus.mem_addr];
      bus.x2_data <= m_x2[bus.mem_addr];
      bus.t_data  <= m_t[bus.mem_addr];
    end
  end

  function automatic logic [DATA_W-1:0] x1v(input int i);
    return DATA_W'(i * 512);
  endfunction
  function automatic logic [DATA_W-1:0] x2v(input int i);
    return DATA_W'(32'hA000 ^ (i * 37));
  endfunction
  function automatic logic [DATA_W-1:0] tv(input int i);
    return (i % 2 == 1) ? 16'hFE00 : 16'h0200;
  endfunction
  function automatic logic [3*DATA_W-1:0] samp_of(input int i);
    return {x1v(i), x2v(i), tv(i)};
  endfunction
  function automatic logic err_of(input int m, input int ep, input int i);
    case (m)
      1:       return (ep == 0) && (i == 1);
      2:       return 1'b1;
      4:       return (i == 0);
      default: return 1'b0;
    endcase
  endfunction

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  logic [3*DATA_W-1:0] sbq [$];
  int cur_n = 0, err_mode = 0, stall_left = 0, hs_i = 0, ep_i = 0, vrun = 0, vrun_max = 0;
  bit wr_seen = 1'b0;

  // Datapath stand-in: drives ready/err at negedge and scores each accepted sample.
  initial begin : mon
    logic                rdy;
    logic [3*DATA_W-1:0] e;
    bus.samp_ready = 1'b0;
    bus.samp_err   = 1'b0;
    forever begin
      @(negedge clk);
      rdy = 1'b1;
      if (bus.samp_valid && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end
      bus.samp_ready = rdy;
      bus.samp_err   = bus.samp_valid ? err_of(err_mode, ep_i, hs_i) : 1'b0;
      #1;
      if (bus.mem_wr_rd !== 1'b0) wr_seen = 1'b1;
      if (bus.samp_valid) begin
        vrun++;
        if (vrun > vrun_max) vrun_max = vrun;
      end else begin
        vrun = 0;
      end
      if (bus.samp_valid) begin
        check("sb_nonempty", (sbq.size() != 0), 1'b1);
        if (sbq.size() != 0) begin
          if (!rdy) begin
            check("stall_data", {bus.samp_x1, bus.samp_x2, bus.samp_t}, sbq[0]);
            check("stall_mem_ena", bus.mem_ena, 1'b0);
          end else begin
            e = sbq.pop_front();
            check("sample", {bus.samp_x1, bus.samp_x2, bus.samp_t}, e);
          end
        end
        if (rdy) begin
          hs_i++;
          if (hs_i == cur_n) begin
            hs_i = 0;
            ep_i++;
          end
        end
      end
    end
  end

  task automatic run_vec(input vec_t t, input int id);
    int edges;
    bit fin;
    int exp_cyc;
    #2;
    sbq.delete();
    for (int e = 0; e < t.ep; e++)
      for (int i = 0; i < t.n; i++) sbq.push_back(samp_of(i));
    cur_n = t.n; err_mode = t.mode; stall_left = t.bp; hs_i = 0; ep_i = 0;
    vrun = 0; vrun_max = 0;
    @(negedge clk);
    start = 1'b1;
    n_samples = NW'(t.n);
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    fin = done;
    while (!fin && edges < 3000) begin
      if (t.poke && edges == 4) begin
        start = 1'b1;
        n_samples = NW'(5);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
      fin = done;
    end
    start = 1'b0;
    check($sformatf("v%0d_done_reached", id), fin, 1'b1);
    check($sformatf("v%0d_busy", id), busy, 1'b0);
    check($sformatf("v%0d_epoch_cnt", id), epoch_cnt, t.ep);
    check($sformatf("v%0d_converged", id), converged, t.conv);
    check($sformatf("v%0d_err_cnt", id), err_cnt, t.err);
    check($sformatf("v%0d_sb_drained", id), sbq.size(), 0);
    check($sformatf("v%0d_mem_ena_idle", id), bus.mem_ena, 1'b0);
    if (t.bp == 0) begin
      exp_cyc = (t.n == 0) ? 1 : t.ep * (PF ? t.n + 3 : 3 * t.n + 1) + 1;
      check($sformatf("v%0d_cycles", id), edges, exp_cyc);
      if (t.n > 0) check($sformatf("v%0d_valid_run", id), vrun_max, PF ? t.n : 1);
    end
  endtask

  vec_t vt [NV];
  bit   got;

  initial begin
    // n, mode, stall, poke, epochs, converged, err_cnt
    vt[0] = '{4, 0, 0, 1'b0, 1, 1'b1, 0};
    vt[1] = '{3, 1, 0, 1'b0, 2, 1'b1, 0};
    vt[2] = '{2, 2, 0, 1'b1, 3, 1'b0, 2};
    vt[3] = '{1, 0, 0, 1'b0, 1, 1'b1, 0};
    vt[4] = '{0, 0, 0, 1'b0, 0, 1'b0, 0};
    vt[5] = '{8, 0, 0, 1'b0, 1, 1'b1, 0};
    vt[6] = '{3, 4, 5, 1'b0, 3, 1'b0, 1};
    vt[7] = '{5, 1, 0, 1'b0, 2, 1'b1, 0};
    for (int i = 0; i < 1024; i++) begin
      m_x1[i] = x1v(i);
      m_x2[i] = x2v(i);
      m_t[i]  = tv(i);
    end

    #12;
    check("rst_status", {busy, done, converged, epoch_cnt, err_cnt}, '0);
    check("rst_bus", {bus.mem_ena, bus.mem_wr_rd, bus.mem_addr, bus.samp_valid,
                      bus.samp_x1, bus.samp_x2, bus.samp_t}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Abort a run while a sample is waiting in ISSUE.
    sbq.delete();
    for (int i = 0; i < 4; i++) sbq.push_back(samp_of(i));
    cur_n = 4; err_mode = 0; stall_left = 0; hs_i = 0; ep_i = 0;
    @(negedge clk);
    start = 1'b1;
    n_samples = NW'(4);
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (bus.samp_valid) got = 1'b1;
    end
    check("reach_issue", got, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("abort_status", {busy, done, converged, epoch_cnt, err_cnt}, '0);
    check("abort_bus", {bus.mem_ena, bus.mem_wr_rd, bus.mem_addr, bus.samp_valid,
                        bus.samp_x1, bus.samp_x2, bus.samp_t}, '0);
    @(negedge clk);
    sbq.delete();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_after_rst", {busy, done, bus.mem_ena, bus.samp_valid}, '0);

    for (int v = 0; v < NV; v++) run_vec(vt[v], v);

    check("wr_rd_never_high", wr_seen, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
